// File: rtl/pin_entry.sv
// ATM PIN entry front-end: captures the card account, collects a 4-digit BCD PIN,
// hands it downstream for authentication and tracks retries, lockout and session.
module pin_entry #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int MAX_TRIES      = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        card_in,
    input  logic [3:0]  card_acc,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        auth_ok,
    input  logic        auth_fail,
    output logic [3:0]  acc_num,
    output logic [15:0] pin,
    output logic        pin_valid,
    output logic        session,
    output logic        locked,
    output logic [2:0]  digit_cnt
);

    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TRY_W-1:0] TRY_LIMIT = TRY_W'(MAX_TRIES);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_ENTER  = 4'hB;
    localparam logic [3:0] KEY_CANCEL = 4'hC;

    typedef enum logic [2:0] {IDLE, COLLECT, SUBMIT, SESSION, LOCKED} state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [TRY_W-1:0] tries;
    logic [TRY_W-1:0] tries_nxt;
    logic             key_digit, key_clear, key_enter, key_cancel;

    assign key_digit  = key_valid && (key_code <= 4'd9);
    assign key_clear  = key_valid && (key_code == KEY_CLEAR);
    assign key_enter  = key_valid && (key_code == KEY_ENTER);
    assign key_cancel = key_valid && (key_code == KEY_CANCEL);
    assign tries_nxt  = tries + TRY_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc_num   <= '0;
            pin       <= '0;
            pin_valid <= 1'b0;
            session   <= 1'b0;
            locked    <= 1'b0;
            digit_cnt <= '0;
            tries     <= '0;
            tmo_cnt   <= '0;
        end else if (state != IDLE && !card_in) begin
            // Card removal outranks every key and auth event.
            state     <= IDLE;
            pin       <= '0;
            digit_cnt <= '0;
            pin_valid <= 1'b0;
            session   <= 1'b0;
            locked    <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tries <= '0;
                    if (card_in) begin
                        acc_num   <= card_acc;
                        pin       <= '0;
                        digit_cnt <= '0;
                        tmo_cnt   <= '0;
                        state     <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (key_valid) begin
                        tmo_cnt <= '0;
                        if (key_digit && digit_cnt != 3'd4) begin
                            pin       <= {pin[11:0], key_code};
                            digit_cnt <= digit_cnt + 3'd1;
                        end else if (key_clear) begin
                            pin       <= '0;
                            digit_cnt <= '0;
                        end else if (key_enter && digit_cnt == 3'd4) begin
                            pin_valid <= 1'b1;
                            state     <= SUBMIT;
                        end else if (key_cancel) begin
                            pin       <= '0;
                            digit_cnt <= '0;
                            state     <= IDLE;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        pin       <= '0;
                        digit_cnt <= '0;
                        tmo_cnt   <= '0;
                        state     <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                SUBMIT: begin
                    // A simultaneous ok/fail is treated as a failure.
                    if (auth_fail) begin
                        pin_valid <= 1'b0;
                        tries     <= tries_nxt;
                        pin       <= '0;
                        digit_cnt <= '0;
                        tmo_cnt   <= '0;
                        if (tries_nxt == TRY_LIMIT) begin
                            locked <= 1'b1;
                            state  <= LOCKED;
                        end else begin
                            state  <= COLLECT;
                        end
                    end else if (auth_ok) begin
                        pin_valid <= 1'b0;
                        tries     <= '0;
                        pin       <= '0;
                        digit_cnt <= '0;
                        session   <= 1'b1;
                        state     <= SESSION;
                    end
                end
                SESSION: begin
                    if (key_cancel) begin
                        session <= 1'b0;
                        state   <= IDLE;
                    end
                end
                LOCKED: begin
                    locked <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry.sv
// Directed-vector bench for pin_entry (TIMEOUT_CYCLES=8, MAX_TRIES=3).
module tb_pin_entry;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        card_in = 1'b0;
    logic [3:0]  card_acc = 4'h0;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        auth_ok = 1'b0;
    logic        auth_fail = 1'b0;
    logic [3:0]  acc_num;
    logic [15:0] pin;
    logic        pin_valid, session, locked;
    logic [2:0]  digit_cnt;

    int n_vec = 0;
    int n_err = 0;

    pin_entry #(.TIMEOUT_CYCLES(8), .MAX_TRIES(3)) dut (
        .clk(clk), .rst(rst), .card_in(card_in), .card_acc(card_acc),
        .key_valid(key_valid), .key_code(key_code),
        .auth_ok(auth_ok), .auth_fail(auth_fail),
        .acc_num(acc_num), .pin(pin), .pin_valid(pin_valid),
        .session(session), .locked(locked), .digit_cnt(digit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] k);
        key_valid = 1'b1;
        key_code  = k;
        tick();
        key_valid = 1'b0;
    endtask

    task automatic insert(input logic [3:0] acc);
        card_acc = acc;
        card_in  = 1'b1;
        tick();
    endtask

    task automatic remove();
        card_in = 1'b0;
        tick();
        tick();
    endtask

    task automatic enter_1234();
        press(4'h1); press(4'h2); press(4'h3); press(4'h4); press(4'hB);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #3;
        n_vec++;
        if ({acc_num, pin, pin_valid, session, locked, digit_cnt} !== 26'd0) begin
            n_err++;
            $display("FAIL reset_outputs got acc=%h pin=%h pv=%b s=%b l=%b dc=%0d exp all 0",
                     acc_num, pin, pin_valid, session, locked, digit_cnt);
        end
        #4 rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        insert(4'h3);
        n_vec++;
        if (acc_num !== 4'h3) begin
            n_err++; $display("FAIL basic_acc got %h exp 3", acc_num);
        end
        press(4'h1);
        press(4'hE);
        n_vec++;
        if (digit_cnt !== 3'd1 || pin !== 16'h0001) begin
            n_err++; $display("FAIL basic_ignore_E got dc=%0d pin=%h exp 1/0001", digit_cnt, pin);
        end
        press(4'h2); press(4'h3); press(4'hB);
        n_vec++;
        if (pin_valid !== 1'b0 || digit_cnt !== 3'd3) begin
            n_err++; $display("FAIL basic_short_enter got pv=%b dc=%0d exp 0/3", pin_valid, digit_cnt);
        end
        press(4'h4);
        n_vec++;
        if (pin !== 16'h1234 || digit_cnt !== 3'd4) begin
            n_err++; $display("FAIL basic_pin got %h dc=%0d exp 1234/4", pin, digit_cnt);
        end
        press(4'hB);
        press(4'h9);
        press(4'hC);
        tick();
        n_vec++;
        if (pin_valid !== 1'b1 || pin !== 16'h1234 || acc_num !== 4'h3) begin
            n_err++; $display("FAIL basic_submit_hold got pv=%b pin=%h acc=%h exp 1/1234/3",
                              pin_valid, pin, acc_num);
        end
        auth_ok = 1'b1; tick(); auth_ok = 1'b0;
        n_vec++;
        if (session !== 1'b1 || pin !== 16'h0000 || pin_valid !== 1'b0) begin
            n_err++; $display("FAIL basic_session got s=%b pin=%h pv=%b exp 1/0000/0",
                              session, pin, pin_valid);
        end
        press(4'hC);
        n_vec++;
        if (session !== 1'b0) begin
            n_err++; $display("FAIL basic_cancel_session got s=%b exp 0", session);
        end
        remove();
    endtask

    task automatic test_clear();
        insert(4'h5);
        press(4'h5); press(4'h6); press(4'hA);
        n_vec++;
        if (pin !== 16'h0000 || digit_cnt !== 3'd0) begin
            n_err++; $display("FAIL clear_zero got pin=%h dc=%0d exp 0000/0", pin, digit_cnt);
        end
        press(4'h7); press(4'h8); press(4'h9); press(4'h0); press(4'h1);
        n_vec++;
        if (pin !== 16'h7890 || digit_cnt !== 3'd4) begin
            n_err++; $display("FAIL clear_pin got pin=%h dc=%0d exp 7890/4", pin, digit_cnt);
        end
        press(4'hB);
        n_vec++;
        if (pin_valid !== 1'b1) begin
            n_err++; $display("FAIL clear_pv got %b exp 1", pin_valid);
        end
        remove();
    endtask

    task automatic test_lockout();
        insert(4'h7);
        for (int i = 1; i <= 3; i++) begin
            enter_1234();
            auth_fail = 1'b1; tick(); auth_fail = 1'b0;
            n_vec++;
            if (locked !== (i == 3) || pin_valid !== 1'b0 || digit_cnt !== 3'd0) begin
                n_err++; $display("FAIL lockout_try%0d got l=%b pv=%b dc=%0d exp %b/0/0",
                                  i, locked, pin_valid, digit_cnt, i == 3);
            end
        end
        press(4'h1); press(4'hC);
        repeat (10) tick();
        n_vec++;
        if (locked !== 1'b1 || digit_cnt !== 3'd0 || pin !== 16'h0000) begin
            n_err++; $display("FAIL lockout_keys got l=%b dc=%0d pin=%h exp 1/0/0000",
                              locked, digit_cnt, pin);
        end
        card_in = 1'b0; tick();
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++; $display("FAIL lockout_release got %b exp 0", locked);
        end
        tick();
    endtask

    task automatic test_both_auth();
        insert(4'h2);
        enter_1234();
        auth_ok = 1'b1; auth_fail = 1'b1; tick(); auth_ok = 1'b0; auth_fail = 1'b0;
        n_vec++;
        if (session !== 1'b0 || pin_valid !== 1'b0 || locked !== 1'b0 || digit_cnt !== 3'd0) begin
            n_err++; $display("FAIL both_auth got s=%b pv=%b l=%b dc=%0d exp 0/0/0/0",
                              session, pin_valid, locked, digit_cnt);
        end
        // Two further failures must lock if the simultaneous case counted as one.
        for (int i = 0; i < 2; i++) begin
            enter_1234();
            auth_fail = 1'b1; tick(); auth_fail = 1'b0;
        end
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++; $display("FAIL both_auth_count got l=%b exp 1", locked);
        end
        remove();
    endtask

    task automatic test_timeout();
        insert(4'h4);
        press(4'h1); press(4'h2);
        repeat (7) tick();
        n_vec++;
        if (digit_cnt !== 3'd2) begin
            n_err++; $display("FAIL timeout_early got dc=%0d exp 2", digit_cnt);
        end
        tick();
        n_vec++;
        if (digit_cnt !== 3'd0 || pin !== 16'h0000) begin
            n_err++; $display("FAIL timeout_expire got dc=%0d pin=%h exp 0/0000", digit_cnt, pin);
        end
        tick();
        press(4'h1); press(4'h2);
        repeat (7) tick();
        press(4'h3);
        n_vec++;
        if (digit_cnt !== 3'd3 || pin !== 16'h0123) begin
            n_err++; $display("FAIL timeout_last_key got dc=%0d pin=%h exp 3/0123", digit_cnt, pin);
        end
        repeat (7) tick();
        n_vec++;
        if (digit_cnt !== 3'd3) begin
            n_err++; $display("FAIL timeout_restart got dc=%0d exp 3", digit_cnt);
        end
        remove();
    endtask

    task automatic test_submit_drop();
        insert(4'h6);
        enter_1234();
        card_in = 1'b0;
        tick();
        n_vec++;
        if (pin_valid !== 1'b0 || pin !== 16'h0000 || digit_cnt !== 3'd0) begin
            n_err++; $display("FAIL submit_drop got pv=%b pin=%h dc=%0d exp 0/0000/0",
                              pin_valid, pin, digit_cnt);
        end
        tick();
    endtask

    task automatic test_reset_session();
        insert(4'h9);
        enter_1234();
        auth_ok = 1'b1; tick(); auth_ok = 1'b0;
        n_vec++;
        if (session !== 1'b1) begin
            n_err++; $display("FAIL rst_sess_open got %b exp 1", session);
        end
        #2 rst = 1'b0;
        #1;
        n_vec++;
        if ({acc_num, pin, pin_valid, session, locked, digit_cnt} !== 26'd0) begin
            n_err++; $display("FAIL rst_async got acc=%h pin=%h pv=%b s=%b l=%b dc=%0d exp all 0",
                              acc_num, pin, pin_valid, session, locked, digit_cnt);
        end
        card_acc = 4'hA;
        #2 rst = 1'b1;
        tick();
        n_vec++;
        if (acc_num !== 4'hA) begin
            n_err++; $display("FAIL rst_recapture got %h exp a", acc_num);
        end
        press(4'h5);
        n_vec++;
        if (digit_cnt !== 3'd1 || pin !== 16'h0005) begin
            n_err++; $display("FAIL rst_collect got dc=%0d pin=%h exp 1/0005", digit_cnt, pin);
        end
        remove();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_clear();
        test_lockout();
        test_both_auth();
        test_timeout();
        test_submit_drop();
        test_reset_session();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
